my_pulse_req: RTL

Source-side initiator for the two-domain pulse/acknowledge handshake. It accepts single-cycle event pulses in its own clock domain and queues them in a saturating pending counter. Each event is driven out as a four-phase level request: `req` rises, the far-domain `ack` is awaited, `req` falls, and `ack` falling is awaited. No event is lost unless the queue is full. The block sits on the transmitting side of every slow↔fast event crossing; the far domain turns each `req` rising edge into one pulse.

---
 rtl/my_sync_pkg.sv | 9 +
 rtl/my_sync_bit.sv | 20 ++
 rtl/my_pulse_req.sv | 81 ++++++++
 3 files changed

// File: rtl/my_sync_pkg.sv
// my_sync_pkg: state encoding and default synchronizer depth shared by
// the pulse/acknowledge handshake blocks.
package my_sync_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;

    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/my_sync_bit.sv
// my_sync_bit: STAGES-deep flop chain bringing one asynchronous level
// into the clk domain.
module my_sync_bit import my_sync_pkg::*; #(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sr;

    always_ff @(posedge clk)
        if (!reset_n) sr <= '0;
        else sr <= {sr[STAGES-2:0], d};

    assign q = sr[STAGES-1];

endmodule

// File: rtl/my_pulse_req.sv
// my_pulse_req: four-phase req/ack initiator fed by a saturating event queue.
// Optional request timeout is enabled by defining MY_PULSE_REQ_TIMEOUT_EN.
module my_pulse_req import my_sync_pkg::*; #(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in,
    input  logic             ack,
    output logic             req,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             done,
    output logic             overflow,
    output logic             timeout
);

    state_t           state, state_d;
    logic             ack_s, launch, full, to_hit;
    logic [CNT_W-1:0] pending_d;

    if (SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("my_pulse_req: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 1");
    end

    my_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ack),
        .q       (ack_s)
    );

    assign launch = state == IDLE && pending != '0;
    assign full   = &pending;

`ifdef MY_PULSE_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk)
        if (!reset_n || launch) to_cnt <= '0;
        else if (state == REQ) to_cnt <= to_cnt + 1'b1;

    // hit on the last REQ cycle so req is high for exactly TIMEOUT_CYC cycles
    assign to_hit = state == REQ && !ack_s && to_cnt == TW'(TIMEOUT_CYC - 1);
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        pending_d = pending;
        state_d   = state == IDLE ? (launch ? REQ : IDLE) :
                    state == REQ  ? ((ack_s || to_hit) ? WAIT_LOW : REQ) :
                                    (ack_s ? WAIT_LOW : IDLE);
        pending_d = (in && !launch) ? (full ? pending : pending + 1'b1) :
                    (!in && launch) ? pending - 1'b1 : pending;
    end

    always_ff @(posedge clk)
        if (!reset_n) begin
            state    <= IDLE;
            pending  <= '0;
            req      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_d;
            pending  <= pending_d;
            req      <= state_d == REQ;
            busy     <= state_d != IDLE || pending_d != '0;
            done     <= state == WAIT_LOW && !ack_s;
            overflow <= in && !launch && full;
            timeout  <= to_hit;
        end

endmodule
